dispense_payment_ctrl: RTL and testbench

Customer-side transaction controller for the fluid dispenser. It accepts a dispense request and drives the fluid type and volume into the dispenser's pricing logic. It registers the quoted final price and stock status, then collects coins until the price is met. It finally issues a one-cycle dispense grant with change, or refunds the full amount on cancel or timeout, and pulses the visit tracker on each completed sale.

---
 rtl/dispense_pkg.sv | 19 +
 rtl/idle_timer.sv | 29 ++
 rtl/dispense_payment_ctrl.sv | 152 +++++++++++++++
 tb/tb_dispense_payment_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dispense_pkg.sv
// rtl/dispense_pkg.sv - shared types and constants for the dispense payment controller
package dispense_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_QUOTE  = 3'd1,
    ST_PAY    = 3'd2,
    ST_DONE   = 3'd3,
    ST_REFUND = 3'd4
  } state_e;

  localparam logic [1:0] FLUID_WATER   = 2'b00;
  localparam logic [1:0] FLUID_JUICE   = 2'b01;
  localparam logic [1:0] FLUID_CHEM    = 2'b10;
  localparam logic [1:0] FLUID_INVALID = 2'b11;

  localparam int PRICE_W_DEFAULT = 16;

endpackage

// File: rtl/idle_timer.sv
// rtl/idle_timer.sv - counts coinless PAY cycles and flags the refund deadline
module idle_timer #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] cnt_q;

  // Fires on the cycle whose increment would reach TIMEOUT_CYCLES-1.
  assign expired = en && !clr && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 2));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/dispense_payment_ctrl.sv
// rtl/dispense_payment_ctrl.sv - request, quote, coin collection and dispense/refund sequencing
module dispense_payment_ctrl
  import dispense_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int PRICE_W        = PRICE_W_DEFAULT
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_fluid,
  input  logic [7:0]         req_volume,
  input  logic [3:0]         req_user,
  output logic [1:0]         disp_fluid,
  output logic [7:0]         disp_volume,
  output logic [3:0]         user_id,
  input  logic [PRICE_W-1:0] quote_price,
  input  logic [7:0]         quote_msg,
  input  logic               coin_valid,
  input  logic [7:0]         coin_value,
  input  logic               cancel,
  output logic               dispense_go,
  output logic [PRICE_W-1:0] change_amount,
  output logic               refund_valid,
  output logic [PRICE_W-1:0] refund_amount,
  output logic               reject,
  output logic               visit_inc,
  output logic [PRICE_W-1:0] paid_total,
  output logic               busy
);

  state_e               state_q;
  logic                 req_ready_q, busy_q;
  logic [1:0]           fluid_q;
  logic [7:0]           volume_q;
  logic [3:0]           user_q;
  logic [PRICE_W-1:0]   price_q, paid_q, change_q, refund_amt_q;
  logic                 go_q, refund_q, reject_q, visit_q;
  logic                 timer_expired;
  logic [PRICE_W:0]     sum_wide;
  logic [PRICE_W-1:0]   paid_d;

  // Running total including this cycle's coin, clamped at all-ones.
  assign sum_wide = {1'b0, paid_q} + (PRICE_W+1)'(coin_value);
  assign paid_d   = !coin_valid        ? paid_q :
                    sum_wide[PRICE_W]  ? '1     : sum_wide[PRICE_W-1:0];

  idle_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     ((state_q != ST_PAY) || coin_valid),
    .en      (state_q == ST_PAY),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      fluid_q      <= '0;
      volume_q     <= '0;
      user_q       <= '0;
      price_q      <= '0;
      paid_q       <= '0;
      change_q     <= '0;
      refund_amt_q <= '0;
      go_q         <= 1'b0;
      refund_q     <= 1'b0;
      reject_q     <= 1'b0;
      visit_q      <= 1'b0;
    end else begin
      go_q         <= 1'b0;
      refund_q     <= 1'b0;
      reject_q     <= 1'b0;
      visit_q      <= 1'b0;
      change_q     <= '0;
      refund_amt_q <= '0;
      case (state_q)
        ST_IDLE: begin
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          if (req_valid && req_ready_q) begin
            state_q     <= ST_QUOTE;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            fluid_q     <= req_fluid;
            volume_q    <= req_volume;
            user_q      <= req_user;
            paid_q      <= '0;
          end
        end
        ST_QUOTE: begin
          price_q <= quote_price;
          if ((quote_msg != 8'd0) || (fluid_q == FLUID_INVALID)) begin
            state_q     <= ST_IDLE;
            reject_q    <= 1'b1;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end else if (quote_price == '0) begin
            state_q <= ST_DONE;
            go_q    <= 1'b1;
            visit_q <= 1'b1;
          end else begin
            state_q <= ST_PAY;
          end
        end
        ST_PAY: begin
          paid_q <= paid_d;
          // Cancel outranks a completing coin; that coin is refunded too.
          if (cancel || timer_expired) begin
            state_q      <= ST_REFUND;
            refund_q     <= 1'b1;
            refund_amt_q <= paid_d;
          end else if (paid_d >= price_q) begin
            state_q  <= ST_DONE;
            go_q     <= 1'b1;
            visit_q  <= 1'b1;
            change_q <= paid_d - price_q;
          end
        end
        ST_DONE, ST_REFUND: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready     = req_ready_q;
  assign busy          = busy_q;
  assign disp_fluid    = fluid_q;
  assign disp_volume   = volume_q;
  assign user_id       = user_q;
  assign paid_total    = paid_q;
  assign dispense_go   = go_q;
  assign change_amount = change_q;
  assign refund_valid  = refund_q;
  assign refund_amount = refund_amt_q;
  assign reject        = reject_q;
  assign visit_inc     = visit_q;

endmodule

// File: tb/tb_dispense_payment_ctrl.sv
// tb/tb_dispense_payment_ctrl.sv - self-checking bench for dispense_payment_ctrl
module tb_dispense_payment_ctrl;

  localparam int TO = 8;
  localparam int K_GO = 0, K_REF = 1, K_REJ = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid = 1'b0, req_ready;
  logic [1:0]  req_fluid = '0, disp_fluid;
  logic [7:0]  req_volume = '0, disp_volume;
  logic [3:0]  req_user = '0, user_id;
  logic [15:0] quote_price = '0;
  logic [7:0]  quote_msg = '0;
  logic        coin_valid = 1'b0;
  logic [7:0]  coin_value = '0;
  logic        cancel = 1'b0;
  logic        dispense_go, refund_valid, reject, visit_inc, busy;
  logic [15:0] change_amount, refund_amount, paid_total;

  int n_chk = 0;
  int n_fail = 0;

  logic       sched_cv [0:511];
  logic [7:0] sched_val[0:511];
  logic       sched_cn [0:511];

  typedef struct {
    logic [1:0]  f;
    logic [7:0]  v;
    logic [3:0]  u;
    logic [15:0] price;
    logic [7:0]  msg;
    int n;
    int ca_s; int ca_v;
    int cb_s; int cb_v;
    int cn_s;
    int ek; int es; int ea; int ep;
  } vec_t;

  vec_t vt[13];

  dispense_payment_ctrl #(.TIMEOUT_CYCLES(TO), .PRICE_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_fluid(req_fluid), .req_volume(req_volume), .req_user(req_user),
    .disp_fluid(disp_fluid), .disp_volume(disp_volume), .user_id(user_id),
    .quote_price(quote_price), .quote_msg(quote_msg),
    .coin_valid(coin_valid), .coin_value(coin_value), .cancel(cancel),
    .dispense_go(dispense_go), .change_amount(change_amount),
    .refund_valid(refund_valid), .refund_amount(refund_amount),
    .reject(reject), .visit_inc(visit_inc), .paid_total(paid_total), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear_sched();
    for (int i = 0; i < 512; i++) begin
      sched_cv[i] = 1'b0; sched_val[i] = 8'd0; sched_cn[i] = 1'b0;
    end
  endtask

  // Outcome from the payment rules: slot = cycles after the accept edge.
  function automatic void model(input logic [15:0] price, input logic [7:0] msg,
                                input logic [1:0] f, input int n,
                                output int k, output int s, output int a, output int p);
    int paid, last, j, val;
    bit cv, cn;
    k = -1; s = -1; a = 0; p = 0;
    if (msg != 0 || f == 2'b11) begin k = K_REJ; s = 1; return; end
    if (price == 0) begin k = K_GO; s = 1; return; end
    paid = 0; last = 1;
    for (int e = 2; e <= n + TO + 2; e++) begin
      j = e - 1;
      cv = (j < n) ? sched_cv[j] : 1'b0;
      cn = (j < n) ? sched_cn[j] : 1'b0;
      val = (j < n) ? int'(sched_val[j]) : 0;
      if (cv) paid = (paid + val > 65535) ? 65535 : paid + val;
      if (cn) begin k = K_REF; s = e; a = paid; p = paid; return; end
      if (paid >= int'(price)) begin k = K_GO; s = e; a = paid - int'(price); p = paid; return; end
      if (cv) last = e;
      else if (e == last + TO - 1) begin k = K_REF; s = e; a = paid; p = paid; return; end
    end
  endfunction

  task automatic run_txn(input string nm, input logic [1:0] f, input logic [7:0] v,
                         input logic [3:0] u, input logic [15:0] price, input logic [7:0] msg,
                         input int n, input int ek, input int es, input int ea, input int ep);
    int guard, pulses, got_k, got_s, got_a, got_p, got_vis, rdy_nx, paid_nx, busy_nx;
    bit amt_bad;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    chk({nm, " ready_before"}, req_ready, 1);
    req_valid = 1'b1; req_fluid = f; req_volume = v; req_user = u;
    quote_price = price; quote_msg = msg; coin_valid = 1'b0; cancel = 1'b0;
    @(negedge clk);
    req_valid = 1'b0; req_fluid = 2'($urandom); req_volume = 8'($urandom); req_user = 4'($urandom);
    chk({nm, " disp_fluid"}, disp_fluid, f);
    chk({nm, " disp_volume"}, disp_volume, v);
    chk({nm, " user_id"}, user_id, u);
    chk({nm, " busy"}, busy, 1);
    pulses = 0; got_k = -1; got_s = -1; got_a = 0; got_p = 0; got_vis = 0;
    rdy_nx = -1; paid_nx = -1; busy_nx = -1; amt_bad = 1'b0;
    for (int j = 0; j <= n + TO + 3; j++) begin
      pulses += int'(dispense_go) + int'(refund_valid) + int'(reject);
      if ((dispense_go || refund_valid || reject) && got_s < 0) begin
        got_s = j;
        got_k = dispense_go ? K_GO : (refund_valid ? K_REF : K_REJ);
        got_a = dispense_go ? int'(change_amount) : int'(refund_amount);
        got_p = int'(paid_total);
        got_vis = int'(visit_inc);
      end else if (visit_inc) amt_bad = 1'b1;
      if (!dispense_go && change_amount != 0) amt_bad = 1'b1;
      if (!refund_valid && refund_amount != 0) amt_bad = 1'b1;
      if (got_s >= 0 && j == got_s + 1) begin
        rdy_nx = int'(req_ready); paid_nx = int'(paid_total); busy_nx = int'(busy);
      end
      coin_valid = (j < n) ? sched_cv[j] : 1'b0;
      coin_value = (j < n) ? sched_val[j] : 8'($urandom);
      cancel     = (j < n) ? sched_cn[j] : 1'b0;
      @(negedge clk);
    end
    coin_valid = 1'b0; cancel = 1'b0;
    chk({nm, " pulse_count"}, pulses, 1);
    chk({nm, " kind"}, got_k, ek);
    chk({nm, " slot"}, got_s, es);
    chk({nm, " amount"}, got_a, ea);
    chk({nm, " paid_total"}, got_p, ep);
    chk({nm, " visit_inc"}, got_vis, (ek == K_GO) ? 1 : 0);
    chk({nm, " stray_outputs"}, amt_bad, 0);
    chk({nm, " ready_after"}, rdy_nx, 1);
    chk({nm, " busy_after"}, busy_nx, 0);
    chk({nm, " paid_hold"}, paid_nx, ep);
  endtask

  initial begin
    int k, s, a, p, n, cnt;
    logic [1:0] rf;
    logic [7:0] rm;
    logic [15:0] rp;

    //            f      v   u   price  msg   n ca_s ca_v cb_s cb_v cn_s  ek     es  ea  ep
    vt[0]  = '{2'b00, 8'd3, 4'd1, 16'd40,  8'd0, 3,  1, 20,  2, 25, -1, K_GO,   3,  5, 45};
    vt[1]  = '{2'b01, 8'd2, 4'd2, 16'd40,  8'd1, 3,  1,  5, -1,  0, -1, K_REJ,  1,  0,  0};
    vt[2]  = '{2'b10, 8'd5, 4'd3, 16'd60,  8'd0, 4,  1, 30,  3, 10,  3, K_REF,  4, 40, 40};
    vt[3]  = '{2'b00, 8'd1, 4'd4, 16'd50,  8'd0, 3,  2, 10, -1,  0, -1, K_REF, 10, 10, 10};
    vt[4]  = '{2'b11, 8'd7, 4'd5, 16'd10,  8'd0, 2,  1, 10, -1,  0, -1, K_REJ,  1,  0,  0};
    vt[5]  = '{2'b01, 8'd9, 4'd6, 16'd0,   8'd0, 2,  0,  9, -1,  0, -1, K_GO,   1,  0,  0};
    vt[6]  = '{2'b00, 8'd2, 4'd7, 16'd30,  8'd0, 2,  1, 30, -1,  0, -1, K_GO,   2,  0, 30};
    vt[7]  = '{2'b10, 8'd4, 4'd8, 16'd20,  8'd0, 2, -1,  0, -1,  0,  1, K_REF,  2,  0,  0};
    vt[8]  = '{2'b01, 8'd6, 4'd9, 16'd20,  8'd0, 1, -1,  0, -1,  0, -1, K_REF,  8,  0,  0};
    vt[9]  = '{2'b00, 8'd8, 4'd10, 16'd10, 8'd0, 2,  1, 10, -1,  0,  1, K_REF,  2, 10, 10};
    vt[10] = '{2'b01, 8'd1, 4'd11, 16'd25, 8'd0, 3,  0, 20,  1, 25, -1, K_GO,   2,  0, 25};
    vt[11] = '{2'b00, 8'd2, 4'd12, 16'd30, 8'd0, 3,  1,  0,  2, 35, -1, K_GO,   3,  5, 35};
    vt[12] = '{2'b10, 8'd3, 4'd13, 16'd100, 8'd0, 6, 5, 10, -1,  0, -1, K_REF, 13, 10, 10};

    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #2;
    chk("reset all_outputs_zero",
        |{req_ready, disp_fluid, disp_volume, user_id, dispense_go, change_amount,
          refund_valid, refund_amount, reject, visit_inc, paid_total, busy}, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("reset req_ready_after", req_ready, 1);
    chk("reset busy_after", busy, 0);

    foreach (vt[i]) begin
      clear_sched();
      if (vt[i].ca_s >= 0) begin sched_cv[vt[i].ca_s] = 1'b1; sched_val[vt[i].ca_s] = 8'(vt[i].ca_v); end
      if (vt[i].cb_s >= 0) begin sched_cv[vt[i].cb_s] = 1'b1; sched_val[vt[i].cb_s] = 8'(vt[i].cb_v); end
      if (vt[i].cn_s >= 0) sched_cn[vt[i].cn_s] = 1'b1;
      run_txn($sformatf("vec%0d", i), vt[i].f, vt[i].v, vt[i].u, vt[i].price, vt[i].msg,
              vt[i].n, vt[i].ek, vt[i].es, vt[i].ea, vt[i].ep);
    end

    // 255 x 257 lands exactly on 65535
    clear_sched();
    for (int j = 1; j <= 300; j++) begin sched_cv[j] = 1'b1; sched_val[j] = 8'd255; end
    run_txn("sat255", 2'b00, 8'd9, 4'd14, 16'hFFFF, 8'd0, 301, K_GO, 258, 0, 65535);

    // 250 x 263 would wrap without clamping
    clear_sched();
    for (int j = 1; j <= 270; j++) begin sched_cv[j] = 1'b1; sched_val[j] = 8'd250; end
    run_txn("sat250", 2'b01, 8'd9, 4'd15, 16'hFFFF, 8'd0, 271, K_GO, 264, 0, 65535);

    // Reset during PAY with 30 paid
    cnt = 0;
    while (req_ready !== 1'b1 && cnt < 20) begin @(negedge clk); cnt++; end
    req_valid = 1'b1; req_fluid = 2'b00; req_volume = 8'd4; req_user = 4'd3;
    quote_price = 16'd100; quote_msg = 8'd0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    coin_valid = 1'b1; coin_value = 8'd30;
    @(negedge clk);
    coin_valid = 1'b0;
    @(negedge clk);
    chk("rstpay paid_before", paid_total, 30);
    chk("rstpay busy_before", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("rstpay all_outputs_zero",
        |{req_ready, disp_fluid, disp_volume, user_id, dispense_go, change_amount,
          refund_valid, refund_amount, reject, visit_inc, paid_total, busy}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    cnt = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      cnt += int'(refund_valid) + int'(dispense_go) + int'(reject);
    end
    chk("rstpay no_pulse", cnt, 0);
    chk("rstpay paid_after", paid_total, 0);
    clear_sched();
    sched_cv[1] = 1'b1; sched_val[1] = 8'd20; sched_cv[2] = 1'b1; sched_val[2] = 8'd25;
    run_txn("rstpay_next", 2'b00, 8'd3, 4'd1, 16'd40, 8'd0, 3, K_GO, 3, 5, 45);

    for (int t = 0; t < 40; t++) begin
      clear_sched();
      n  = int'($urandom_range(1, 20));
      rf = 2'($urandom);
      rm = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
      rp = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 200));
      for (int j = 0; j < n; j++) begin
        sched_cv[j]  = ($urandom_range(0, 2) == 0);
        sched_val[j] = 8'($urandom_range(0, 80));
        sched_cn[j]  = ($urandom_range(0, 29) == 0);
      end
      model(rp, rm, rf, n, k, s, a, p);
      run_txn($sformatf("rand%0d", t), rf, 8'($urandom), 4'($urandom), rp, rm, n, k, s, a, p);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
